// File: rtl/ring_noc_pkg.sv
// Shared definitions for the ring NoC: flit field layout, port encoding,
// and the header helpers used by every ring stop.
package ring_noc_pkg;

  localparam int FW       = 64;
  localparam int AW       = 4;
  localparam int SRC_LSB  = 0;
  localparam int DEST_LSB = 4;
  localparam int NPORT    = 3;

  typedef enum logic [1:0] {
    PORT_LOCAL = 2'd0,
    PORT_EAST  = 2'd1,
    PORT_WEST  = 2'd2
  } port_e;

  // A flit carries traffic only when its dest differs from its src;
  // anything else (including all-zero) is an idle slot.
  function automatic logic flit_valid(input logic [2*AW-1:0] hdr);
    return hdr[SRC_LSB +: AW] != hdr[DEST_LSB +: AW];
  endfunction

  // Pick the shorter ring direction. The forward distance is taken modulo
  // n in AW+1 bits so dest+n never wraps; a tie at n/2 goes east.
  function automatic port_e ring_route(input logic [AW-1:0] dest,
                                       input logic [AW-1:0] src_addr,
                                       input logic [AW-1:0] n);
    logic [AW:0] d;
    logic [AW:0] half;
    if (dest == src_addr) return PORT_LOCAL;
    if (dest > src_addr) d = {1'b0, dest} - {1'b0, src_addr};
    else                 d = {1'b0, dest} + {1'b0, n} - {1'b0, src_addr};
    half = {1'b0, n} >> 1;
    return (d <= half) ? PORT_EAST : PORT_WEST;
  endfunction

  // Round-robin successor over the three ports: local -> east -> west -> local.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/ring_flit_fifo.sv
// Per-input flit buffer. Power-of-two depth, pointer wrap by overflow,
// occupancy counter for full/empty. A write to a full FIFO is accepted
// only when a pop happens on the same edge.
module ring_flit_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ring_router.sv
// Three-port store-and-forward ring stop. Each input feeds its own FIFO;
// FIFO heads are routed (local / east / west / drop), each output runs a
// round-robin arbiter over the heads requesting it, and the winners are
// registered onto the outputs. Ungranted outputs go idle (zero).
module ring_router #(
  parameter int FW    = 64,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] n,
  input  logic [FW-1:0] in_local,
  input  logic [FW-1:0] in_east,
  input  logic [FW-1:0] in_west,
  output logic [FW-1:0] out_local,
  output logic [FW-1:0] out_east,
  output logic [FW-1:0] out_west
);

  import ring_noc_pkg::*;

  logic [FW-1:0] in_flit [NPORT];
  logic [FW-1:0] head    [NPORT];
  logic          empty   [NPORT];
  logic          full    [NPORT];
  logic          wr_en   [NPORT];
  logic          pop     [NPORT];
  logic          drop    [NPORT];
  port_e         route   [NPORT];
  logic [AW-1:0] dest    [NPORT];

  // req[o][p]: head of input p wants output o
  logic [NPORT-1:0] req     [NPORT];
  logic             gnt_vld [NPORT];
  logic [1:0]       gnt_idx [NPORT];
  logic [1:0]       cand    [NPORT];

  logic [1:0]    last_q [NPORT];
  logic [1:0]    last_d [NPORT];
  logic [FW-1:0] out_q  [NPORT];
  logic [FW-1:0] out_d  [NPORT];

  assign in_flit[PORT_LOCAL] = in_local;
  assign in_flit[PORT_EAST]  = in_east;
  assign in_flit[PORT_WEST]  = in_west;

  assign out_local = out_q[PORT_LOCAL];
  assign out_east  = out_q[PORT_EAST];
  assign out_west  = out_q[PORT_WEST];

  for (genvar p = 0; p < NPORT; p++) begin : g_in
    ring_flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en[p]),
      .wr_data_i (in_flit[p]),
      .rd_en_i   (pop[p]),
      .rd_data_o (head[p]),
      .empty_o   (empty[p]),
      .full_o    (full[p])
    );
  end

  // Route each FIFO head; heads addressed beyond the ring size are discarded.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      dest[p]  = head[p][DEST_LSB +: AW];
      drop[p]  = ~empty[p] & (dest[p] >= n);
      route[p] = ring_route(dest[p], src_addr, n);
    end
  end

  // Build per-output request vectors from the routed heads.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      req[o] = '0;
      for (int p = 0; p < NPORT; p++) begin
        req[o][p] = ~empty[p] & ~drop[p] & (2'(route[p]) == 2'(o));
      end
    end
  end

  // Round-robin per output, scanning from the port after the last winner.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = last_q[o];
      cand[o]    = last_q[o];
      for (int k = 0; k < NPORT; k++) begin
        cand[o] = rr_next(cand[o]);
        if (!gnt_vld[o] && req[o][cand[o]]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = cand[o];
        end
      end
    end
  end

  // Pop granted or dropped heads; admit valid arrivals unless the FIFO
  // stays full this edge.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      pop[p] = drop[p];
      for (int o = 0; o < NPORT; o++) begin
        if (gnt_vld[o] && (gnt_idx[o] == 2'(p))) pop[p] = 1'b1;
      end
      wr_en[p] = flit_valid(in_flit[p][2*AW-1:0]) & (~full[p] | pop[p]);
    end
  end

  // Output data and arbiter pointer next state.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      out_d[o]  = '0;
      last_d[o] = last_q[o];
      if (gnt_vld[o]) begin
        out_d[o]  = head[gnt_idx[o]];
        last_d[o] = gnt_idx[o];
      end
    end
  end

  // Registered outputs and round-robin pointers; reset idles all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NPORT; o++) begin
        out_q[o]  <= '0;
        last_q[o] <= 2'(PORT_LOCAL);
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        out_q[o]  <= out_d[o];
        last_q[o] <= last_d[o];
      end
    end
  end

endmodule

// File: tb/tb_ring_router.sv
// Directed bench for ring_router at node 2 of an 8-node ring.
module tb_ring_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_addr, n;
  logic [63:0] in_local, in_east, in_west;
  logic [63:0] out_local, out_east, out_west;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  wsend [15] = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                              8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h2F};
  logic [7:0]  wexp  [11] = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                              8'h29, 8'h2B, 8'h2D, 8'h2F};
  logic [63:0] wobs  [16];
  int          wcnt, ecnt, tot;
  logic [63:0] side_or;

  ring_router #(.FW(64), .AW(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_addr  (src_addr),
    .n         (n),
    .in_local  (in_local),
    .in_east   (in_east),
    .in_west   (in_west),
    .out_local (out_local),
    .out_east  (out_east),
    .out_west  (out_west)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [63:0] l, input logic [63:0] e,
                      input logic [63:0] w);
    chk({tag, ".local"}, out_local, l);
    chk({tag, ".east"},  out_east,  e);
    chk({tag, ".west"},  out_west,  w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_local = '0;
    in_east  = '0;
    in_west  = '0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    src_addr = 4'd2;
    n        = 4'd8;
    idle_in();
    #2;
    chk3("reset", 0, 0, 0);
    tick();
    rst = 1'b0;

    // idle inputs, including a dest==src flit, produce nothing
    tick(); tick();
    chk3("idle", 0, 0, 0);
    in_local = 64'h22;
    tick(); idle_in();
    tick();
    chk3("idle22_a", 0, 0, 0);
    tick();
    chk3("idle22_b", 0, 0, 0);

    // eastward, with minimum-latency and no-hold boundaries
    in_local = 64'h52;
    tick(); idle_in();
    chk3("east52_early", 0, 0, 0);
    tick();
    chk3("east52", 0, 64'h52, 0);
    tick();
    chk3("east52_nohold", 0, 0, 0);

    in_local = 64'h62;
    tick(); idle_in(); tick();
    chk3("tie62", 0, 64'h62, 0);

    // westward
    in_local = 64'h72;
    tick(); idle_in(); tick();
    chk3("west72", 0, 0, 64'h72);
    in_east = 64'h05;
    tick(); idle_in(); tick();
    chk3("west05", 0, 0, 64'h05);

    // dest beyond ring size is dropped
    in_local = 64'h92;
    tick(); idle_in(); tick();
    chk3("drop92_a", 0, 0, 0);
    tick();
    chk3("drop92_b", 0, 0, 0);

    // ejection
    in_west = 64'h20;
    tick(); idle_in(); tick();
    chk3("eject20", 64'h20, 0, 0);
    in_west = 64'hABCD_0020;
    tick(); idle_in(); tick();
    chk3("eject_payload", 64'hABCD_0020, 0, 0);

    // async reset mid-traffic
    in_local = 64'h52;
    tick();
    in_local = 64'h62;
    tick();
    in_local = 64'h72;
    chk("pre_reset.east", out_east, 64'h52);
    rst = 1'b1;
    #1;
    chk3("reset_async", 0, 0, 0);
    tick();
    idle_in();
    rst = 1'b0;
    tick();
    chk3("post_reset_a", 0, 0, 0);
    tick();
    chk3("post_reset_b", 0, 0, 0);
    tick();
    chk3("post_reset_c", 0, 0, 0);

    // contention to local: east wins first after reset, then alternation
    rst_pulse();
    in_east = 64'h24;  in_west = 64'h21;
    tick();
    in_east = 64'h124; in_west = 64'h121;
    tick(); idle_in();
    chk3("rr_1", 64'h24, 0, 0);
    tick();
    chk3("rr_2", 64'h21, 0, 0);
    tick();
    chk3("rr_3", 64'h124, 0, 0);
    tick();
    chk3("rr_4", 64'h121, 0, 0);
    tick();
    chk3("rr_idle", 0, 0, 0);

    // overflow: west stream competes with an east stream for local
    rst_pulse();
    wcnt = 0; ecnt = 0; tot = 0; side_or = '0;
    for (int c = 0; c < 30; c++) begin
      if (c < 15) begin
        in_west = {56'h0, wsend[c]};
        in_east = 64'h23 | (64'(c + 1) << 8);
      end else begin
        idle_in();
      end
      tick();
      side_or = side_or | out_east | out_west;
      if (out_local != '0) begin
        tot++;
        if (out_local[15:8] == 8'h00) begin
          if (wcnt < 16) wobs[wcnt] = out_local;
          wcnt++;
        end else begin
          ecnt++;
        end
      end
    end
    idle_in();
    chk("ovf.west_ejected", 64'(wcnt), 64'd11);
    chk("ovf.west_dropped", 64'(15 - wcnt), 64'd4);
    chk("ovf.east_ejected", 64'(ecnt), 64'd11);
    chk("ovf.total", 64'(tot), 64'd22);
    chk("ovf.side_idle", side_or, 64'h0);
    for (int i = 0; i < 11; i++) begin
      if (i < wcnt) chk($sformatf("ovf.order%0d", i), wobs[i], {56'h0, wexp[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
